// File: rtl/pc_seq_ctrl_if.sv
// Instruction-memory fetch bus between the PC sequencer (master) and instruction memory (slave).
interface pc_seq_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle PC sequencer: FETCH -> WAIT -> EXEC per instruction, committing the next PC
// from the branch-condition selects, with an absorbing HALT state for ebreak or misaligned targets.
module pc_seq_ctrl #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_seq_ctrl_if.master        bus,
    output logic [31:0]          inst,
    output logic                 inst_valid,
    input  logic                 exu_done,
    input  logic                 PCAsrc,
    input  logic                 PCBsrc,
    input  logic [XLEN-1:0]      imm,
    input  logic [XLEN-1:0]      rs1,
    input  logic                 halt_req,
    output logic [XLEN-1:0]      pc,
    output logic                 halted,
    output logic                 misalign
);

    typedef enum logic [1:0] {StFetch, StWait, StExec, StHalt} state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     inst_q;
    logic            inst_valid_q;
    logic            req_valid_q;
    logic            halted_q;
    logic            misalign_q;

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] addend;
    logic [XLEN-1:0] target;

    always_comb begin
        base   = PCBsrc ? rs1 : pc_q;
        addend = PCAsrc ? imm : XLEN'(4);
        target = base + addend;
        // jalr drops bit 0 before the alignment check
        if (PCAsrc && PCBsrc) begin
            target[0] = 1'b0;
        end
    end

    // The request flag is its own register so it reads 0 while reset is held and rises on
    // the first clock after release; ready only counts once the request is visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            req_valid_q  <= 1'b0;
            halted_q     <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            inst_valid_q <= 1'b0;
            unique case (state_q)
                StFetch: begin
                    if (!req_valid_q) begin
                        req_valid_q <= 1'b1;
                    end else if (bus.imem_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= StWait;
                    end
                end
                StWait: begin
                    if (bus.imem_resp_valid) begin
                        inst_q       <= bus.imem_resp_data;
                        inst_valid_q <= 1'b1;
                        state_q      <= StExec;
                    end
                end
                StExec: begin
                    if (exu_done) begin
                        if (halt_req) begin
                            halted_q <= 1'b1;
                            state_q  <= StHalt;
                        end else if (target[1:0] != 2'b00) begin
                            misalign_q <= 1'b1;
                            halted_q   <= 1'b1;
                            state_q    <= StHalt;
                        end else begin
                            pc_q        <= target;
                            req_valid_q <= 1'b1;
                            state_q     <= StFetch;
                        end
                    end
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: begin
                    state_q <= StHalt;
                end
            endcase
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_addr      = pc_q;
    assign inst               = inst_q;
    assign inst_valid         = inst_valid_q;
    assign pc                 = pc_q;
    assign halted             = halted_q;
    assign misalign           = misalign_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: randomized fetch/execute traffic against a PC reference model.
module tb_pc_seq_ctrl;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] inst;
    logic        inst_valid;
    logic        exu_done = 1'b0;
    logic        PCAsrc = 1'b0;
    logic        PCBsrc = 1'b0;
    logic [31:0] imm = '0;
    logic [31:0] rs1 = '0;
    logic        halt_req = 1'b0;
    logic [31:0] pc;
    logic        halted;
    logic        misalign;

    pc_seq_ctrl_if #(.XLEN(32)) bus ();

    pc_seq_ctrl #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .inst       (inst),
        .inst_valid (inst_valid),
        .exu_done   (exu_done),
        .PCAsrc     (PCAsrc),
        .PCBsrc     (PCBsrc),
        .imm        (imm),
        .rs1        (rs1),
        .halt_req   (halt_req),
        .pc         (pc),
        .halted     (halted),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    bit          model_halted;
    bit          model_misalign;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural rule: target = base + addend mod 2^32, jalr clears bit 0,
    // halt wins, otherwise a target not divisible by 4 halts with misalign.
    function automatic void model_commit(bit a, bit b, logic [31:0] i, logic [31:0] r, bit h);
        longint unsigned base, add, t;
        if (model_halted) return;
        base = b ? longint'(r) : longint'(model_pc);
        add  = a ? longint'(i) : 64'd4;
        t    = (base + add) % (64'd1 << 32);
        if (a && b) t = t - (t % 2);
        if (h) begin
            model_halted = 1'b1;
        end else if (t % 4 != 0) begin
            model_halted   = 1'b1;
            model_misalign = 1'b1;
        end else begin
            model_pc = 32'(t);
        end
    endfunction

    // Monitor: every inst_valid pulse must match the next queued fetched word.
    always @(negedge clk) begin
        if (!rst && inst_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_inst_valid", {63'd0, inst_valid}, 64'd0);
            end else begin
                check("inst_word", {32'd0, inst}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic do_reset(input bit stale);
        @(negedge clk);
        rst = 1'b1;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        exu_done = 1'b0;
        halt_req = 1'b0;
        model_pc = RESET_PC;
        model_halted = 1'b0;
        model_misalign = 1'b0;
        exp_q.delete();
        #1;
        check("rst_req_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        check("rst_pc", {32'd0, pc}, {32'd0, RESET_PC});
        @(negedge clk);
        check("rst_inst", {32'd0, inst}, 64'd0);
        check("rst_flags", {61'd0, inst_valid, halted, misalign}, 64'd0);
        rst = 1'b0;
        bus.imem_resp_valid = stale;
        bus.imem_resp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.imem_resp_valid = 1'b0;
        check("post_rst_req", {31'd0, bus.imem_req_valid, bus.imem_addr}, {31'd0, 1'b1, RESET_PC});
        check("post_rst_inst", {32'd0, inst}, 64'd0);
    endtask

    task automatic fetch_one(input logic [31:0] d, input int ready_delay, input int resp_delay);
        int n = 0;
        while (!bus.imem_req_valid && n < 4) begin
            @(negedge clk);
            n++;
        end
        check("fetch_req", {31'd0, bus.imem_req_valid, bus.imem_addr}, {31'd0, 1'b1, model_pc});
        repeat (ready_delay) begin
            bus.imem_resp_valid = 1'($urandom);
            exu_done = 1'($urandom);
            halt_req = 1'($urandom);
            @(negedge clk);
            check("req_held", {31'd0, bus.imem_req_valid, bus.imem_addr}, {31'd0, 1'b1, model_pc});
        end
        bus.imem_resp_valid = 1'b0;
        exu_done = 1'b0;
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        check("req_dropped", {63'd0, bus.imem_req_valid}, 64'd0);
        repeat (resp_delay) begin
            bus.imem_req_ready = 1'($urandom);
            exu_done = 1'($urandom);
            halt_req = 1'($urandom);
            @(negedge clk);
        end
        bus.imem_req_ready = 1'b0;
        exu_done = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = d;
        exp_q.push_back(d);
        @(negedge clk);
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = $urandom;
    endtask

    task automatic exec(input bit a, input bit b, input logic [31:0] i, input logic [31:0] r,
                        input bit h, input int delay);
        repeat (delay) begin
            bus.imem_req_ready  = 1'($urandom);
            bus.imem_resp_valid = 1'($urandom);
            PCAsrc = 1'($urandom);
            PCBsrc = 1'($urandom);
            imm = $urandom;
            rs1 = $urandom;
            halt_req = 1'($urandom);
            @(negedge clk);
        end
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        exu_done = 1'b1;
        PCAsrc = a;
        PCBsrc = b;
        imm = i;
        rs1 = r;
        halt_req = h;
        model_commit(a, b, i, r, h);
        @(negedge clk);
        exu_done = 1'b0;
        halt_req = 1'b0;
        check("commit_pc", {32'd0, pc}, {32'd0, model_pc});
        check("commit_flags", {62'd0, halted, misalign}, {62'd0, model_halted, model_misalign});
        check("next_req", {63'd0, bus.imem_req_valid}, {63'd0, !model_halted});
    endtask

    task automatic check_halted(input int cycles);
        repeat (cycles) begin
            bus.imem_req_ready  = 1'b1;
            bus.imem_resp_valid = 1'($urandom);
            exu_done = 1'($urandom);
            PCAsrc = 1'($urandom);
            imm = $urandom;
            @(negedge clk);
            check("halt_frozen", {30'd0, bus.imem_req_valid, halted, pc},
                  {30'd0, 1'b0, 1'b1, model_pc});
        end
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        exu_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;

        // Idle memory: request held, address stable, no advance.
        do_reset(1'b0);
        repeat (10) begin
            @(negedge clk);
            check("idle_req", {31'd0, bus.imem_req_valid, bus.imem_addr}, {31'd0, 1'b1, RESET_PC});
        end

        // Sequential, branch, taken branch back, jalr.
        fetch_one(32'h0000_0013, 0, 0);
        exec(1'b0, 1'b0, $urandom, $urandom, 1'b0, 0);
        check("seq_pc", {32'd0, pc}, {32'd0, 32'h8000_0004});
        fetch_one($urandom, 1, 2);
        exec(1'b1, 1'b0, 32'h0000_000C, $urandom, 1'b0, 1);
        check("fwd_branch_pc", {32'd0, pc}, {32'd0, 32'h8000_0010});
        fetch_one($urandom, 0, 1);
        exec(1'b1, 1'b0, 32'hFFFF_FFF8, $urandom, 1'b0, 2);
        check("taken_branch_pc", {32'd0, pc}, {32'd0, 32'h8000_0008});
        fetch_one($urandom, 2, 0);
        exec(1'b1, 1'b1, 32'h0000_0003, 32'h8000_0101, 1'b0, 0);
        check("jalr_pc", {32'd0, pc}, {32'd0, 32'h8000_0104});

        // Randomized traffic that always produces aligned targets.
        for (int k = 0; k < 30; k++) begin
            int          kind;
            logic [31:0] ri;
            logic [31:0] rr;
            kind = $urandom_range(0, 3);
            ri = $urandom & 32'h0000_0FFC;
            rr = ($urandom & 32'hFFFF_FFFC);
            fetch_one($urandom, $urandom_range(0, 3), $urandom_range(0, 3));
            unique case (kind)
                0: exec(1'b0, 1'b0, $urandom, $urandom, 1'b0, $urandom_range(0, 3));
                1: exec(1'b1, 1'b0, ri, $urandom, 1'b0, $urandom_range(0, 3));
                2: exec(1'b1, 1'b1, ri, rr | 32'($urandom_range(0, 1)), 1'b0,
                        $urandom_range(0, 3));
                default: exec(1'b0, 1'b1, $urandom, rr, 1'b0, $urandom_range(0, 3));
            endcase
        end

        // Misaligned jalr target halts with pc unchanged.
        fetch_one($urandom, 0, 0);
        exec(1'b1, 1'b1, 32'h0000_0000, 32'h8000_0102, 1'b0, 1);
        check("misalign_flag", {62'd0, misalign, halted}, {62'd0, 2'b11});
        check_halted(5);

        // halt_req wins over a misaligned target.
        do_reset(1'b0);
        fetch_one($urandom, 1, 1);
        exec(1'b1, 1'b0, 32'h0000_0002, $urandom, 1'b1, 1);
        check("halt_state", {62'd0, halted, misalign}, {62'd0, 2'b10});
        check("halt_pc", {32'd0, pc}, {32'd0, RESET_PC});
        check_halted(20);

        // Reset while a request is outstanding; stale response must be ignored.
        do_reset(1'b0);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        check("wait_entered", {63'd0, bus.imem_req_valid}, 64'd0);
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        check("stale_ignored", {32'd0, inst}, 64'd0);
        check("stale_queue", {32'd0, 32'(exp_q.size())}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Multi-cycle program-counter sequencer for the NPC core.
- Owns the architectural PC and runs the instruction-memory fetch handshake.
- Hands each fetched instruction to decode/execute, then commits the next PC.
- Next PC is built from the branch-condition selects: A-side picks 4 or imm, B-side picks current PC or rs1.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  XLEN  fetch address; always equals pc.
- imem_resp_valid  in  1  fetch data valid.
- imem_resp_data  in  32  fetched instruction word.
- inst  out  32  instruction register, held stable from capture until the next capture.
- inst_valid  out  1  one-cycle pulse when inst is newly captured.
- exu_done  in  1  execute stage finished; PCAsrc, PCBsrc, imm and rs1 are valid in this cycle.
- PCAsrc  in  1  0: addend is 4; 1: addend is imm.
- PCBsrc  in  1  0: base is pc; 1: base is rs1.
- imm  in  XLEN  immediate operand.
- rs1  in  XLEN  rs1 register value.
- halt_req  in  1  ebreak/halt request, sampled together with exu_done.
- pc  out  XLEN  architectural PC.
- halted  out  1  core stopped.
- misalign  out  1  sticky flag: committed target was not 4-byte aligned.

Behaviour:
- Reset (asynchronous, any state, mid-handshake included):
  - state=FETCH, pc=RESET_PC.
  - inst=0, inst_valid=0, halted=0, misalign=0.
  - imem_req_valid=0 during reset; it goes to 1 in the first cycle after rst deasserts.
  - A response arriving after reset that belongs to a pre-reset request is ignored, because state is FETCH, not WAIT.
- States: FETCH, WAIT, EXEC, HALT. All outputs are registered.
- FETCH:
  - Drive imem_req_valid=1 and imem_addr=pc.
  - If imem_req_ready is high this cycle, go to WAIT next cycle.
  - Otherwise stay in FETCH with the request held and address stable; a request is never withdrawn.
- WAIT:
  - imem_req_valid=0.
  - When imem_resp_valid=1: capture inst=imem_resp_data, pulse inst_valid=1 for the following cycle, go to EXEC.
  - A response in the same cycle as request acceptance is not supported; the earliest response is the cycle after acceptance.
- EXEC: wait for exu_done, with no timeout. On exu_done:
  - target = (PCBsrc ? rs1 : pc) + (PCAsrc ? imm : 4), modulo 2^XLEN, carry dropped.
  - If PCAsrc=1 and PCBsrc=1 (jalr), clear bit 0 of target before the alignment check.
  - If halt_req=1: pc is unchanged, go to HALT, halted=1. halt_req takes priority over target computation and over the misalign check.
  - Else if target[1:0] != 0: pc is unchanged, misalign=1, go to HALT, halted=1.
  - Else: pc=target and go to FETCH. The next request is issued the cycle after commit.
- HALT: absorbing state; only rst leaves it. No requests are issued and pc is frozen.
- Signals outside their states are ignored:
  - exu_done outside EXEC.
  - imem_resp_valid outside WAIT.
  - imem_req_ready outside FETCH.
- Minimum instruction latency, with ready and response both immediate and exu_done on the first EXEC cycle: 3 cycles per instruction (FETCH, WAIT, EXEC).
- inst_valid is 1 in exactly one cycle per fetched instruction.

Test Plan:
- Reset then idle memory (ready=0): pc=0x8000_0000, imem_req_valid=1 held for 10 cycles with imem_addr constant, no state advance.
- Sequential flow: ready=1, response 1 cycle later with data 0x00000013, exu_done with PCAsrc=0, PCBsrc=0 -> pc=0x8000_0004; second fetch addresses 0x8000_0004; inst_valid pulses once per instruction.
- Taken branch: pc=0x8000_0010, PCAsrc=1, PCBsrc=0, imm=0xFFFF_FFF8 -> pc=0x8000_0008.
- jalr: PCAsrc=1, PCBsrc=1, rs1=0x8000_0101, imm=0x3 -> sum 0x8000_0104, bit 0 already clear, pc=0x8000_0104. Second case: rs1=0x8000_0102, imm=0 -> target 0x8000_0102, misalign=1, halted=1, pc unchanged.
- Halt: exu_done with halt_req=1 and PCAsrc=1 -> halted=1, pc unchanged, imem_req_valid stays 0 for 20 cycles.
- Reset mid-WAIT: rst pulsed while a request is outstanding, then a stale imem_resp_valid arrives in the FETCH cycle -> inst stays 0, no inst_valid pulse, a new request is issued at 0x8000_0000.
